// File: rtl/shift_seq.sv
// Iterative shifter: logical left, logical right or arithmetic right, one bit
// position per clock, under a start/done handshake. Results match the barrel shifter.
module shift_seq #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 right_en,
  input  logic                 sign,
  input  logic [N-1:0]         din,
  input  logic [$clog2(N):0]   shift_n,
  output logic                 ready,
  output logic                 done,
  output logic [N-1:0]         out
);

  localparam int W = $clog2(N) + 1;
  localparam logic [W-1:0] NW = W'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [W-1:0]   cnt, cnt_nx;
  logic [N-1:0]   out_nx;
  logic           right_q, right_nx;
  logic           sign_q, sign_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    out_nx   = out;
    right_nx = right_q;
    sign_nx  = sign_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          out_nx   = din;
          right_nx = right_en;
          sign_nx  = sign;
          // Clamping to N makes any over-range amount flush the operand completely.
          cnt_nx   = (shift_n > NW) ? NW : shift_n;
          state_nx = (cnt_nx == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (right_q) out_nx = {sign_q & out[N-1], out[N-1:1]};
        else         out_nx = {out[N-2:0], 1'b0};
        cnt_nx = cnt - W'(1);
        if (cnt == W'(1)) state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ready/done are flopped from the next-state value so they are plain registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      out     <= '0;
      right_q <= 1'b0;
      sign_q  <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      out     <= out_nx;
      right_q <= right_nx;
      sign_q  <= sign_nx;
      ready   <= (state_nx == S_IDLE);
      done    <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq (N=8): a cycle model built from the shift
// operators plus directed literal expectations.
module tb_shift_seq;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       right_en = 1'b0;
  logic       sign = 1'b0;
  logic [7:0] din = '0;
  logic [3:0] shift_n = '0;
  logic       ready, done;
  logic [7:0] out;

  int tests = 0;
  int fails = 0;

  shift_seq #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .right_en(right_en), .sign(sign),
    .din(din), .shift_n(shift_n), .ready(ready), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] golden(logic [7:0] d, logic [3:0] s, logic r, logic sg);
    logic [7:0] res;
    if (!r)       res = d << s;
    else if (!sg) res = d >> s;
    else          res = $signed(d) >>> s;
    return res;
  endfunction

  function automatic int clampn(logic [3:0] s);
    return (int'(s) > N) ? N : int'(s);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: accept when idle, done arrives min(shift_n,N) edges after accept.
  logic       m_ready = 1'b1;
  logic       m_done = 1'b0;
  logic [7:0] m_out = '0;
  logic [7:0] m_exp = '0;
  int         m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_done  <= 1'b0;
      m_out   <= '0;
      m_rem   <= 0;
    end else if (m_ready) begin
      if (start) begin
        m_ready <= 1'b0;
        m_exp   <= golden(din, shift_n, right_en, sign);
        m_rem   <= clampn(shift_n);
        if (clampn(shift_n) == 0) begin
          m_done <= 1'b1;
          m_out  <= golden(din, shift_n, right_en, sign);
        end
      end
    end else if (m_done) begin
      m_done  <= 1'b0;
      m_ready <= 1'b1;
    end else begin
      if (m_rem == 1) begin
        m_done <= 1'b1;
        m_out  <= m_exp;
      end
      m_rem <= m_rem - 1;
    end
  end

  always @(negedge clk) begin
    if ($time > 0) begin
      chk("ready", 32'(ready), 32'(m_ready));
      chk("done", 32'(done), 32'(m_done));
      if (m_ready || m_done) chk("out", 32'(out), 32'(m_out));
    end
  end

  task automatic do_op(input logic [7:0] d, input logic [3:0] s, input logic r,
                       input logic sg, output logic [7:0] res, output int edges);
    int g;
    g = 0;
    while (!ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    din = d; shift_n = s; right_en = r; sign = sg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (!done && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    res = out;
  endtask

  logic [7:0] res;
  int         edges;
  int         g;

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed literals
    do_op(8'b1011_0011, 4'd0, 1'b0, 1'b0, res, edges);
    chk("zero_out", 32'(res), 32'hB3);
    chk("zero_lat", 32'(edges), 32'd0);
    do_op(8'b1011_0011, 4'd7, 1'b0, 1'b0, res, edges);
    chk("max_left_out", 32'(res), 32'h80);
    chk("max_left_lat", 32'(edges), 32'd7);
    do_op(8'b1001_0000, 4'd3, 1'b1, 1'b1, res, edges);
    chk("asr_out", 32'(res), 32'hF2);
    chk("asr_lat", 32'(edges), 32'd3);
    do_op(8'b1001_0000, 4'd3, 1'b1, 1'b0, res, edges);
    chk("lsr_out", 32'(res), 32'h12);
    do_op(8'hB3, 4'd1, 1'b0, 1'b1, res, edges);
    chk("left_sign_ignored", 32'(res), 32'h66);
    do_op(8'hFF, 4'd12, 1'b0, 1'b0, res, edges);
    chk("ovr_left_out", 32'(res), 32'h00);
    chk("ovr_left_lat", 32'(edges), 32'd8);
    do_op(8'hFF, 4'd12, 1'b1, 1'b0, res, edges);
    chk("ovr_lsr_out", 32'(res), 32'h00);
    chk("ovr_lsr_lat", 32'(edges), 32'd8);
    do_op(8'h80, 4'd12, 1'b1, 1'b1, res, edges);
    chk("ovr_asr_out", 32'(res), 32'hFF);
    chk("ovr_asr_lat", 32'(edges), 32'd8);

    // Reset mid-SHIFT aborts at once
    @(negedge clk);
    din = 8'hA5; shift_n = 4'd5; right_en = 1'b1; sign = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out", 32'(out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'hA5, 4'd5, 1'b1, 1'b1, res, edges);
    chk("post_rst_out", 32'(res), 32'hFD);
    chk("post_rst_lat", 32'(edges), 32'd5);

    // Operand churn while busy: only accept-edge operands count
    @(negedge clk);
    din = 8'h3C; shift_n = 4'd2; right_en = 1'b0; sign = 1'b0; start = 1'b1;
    @(negedge clk);
    g = 0;
    while (!done && g < 20) begin
      start = g[0];
      din = 8'($urandom);
      shift_n = 4'($urandom);
      right_en = 1'($urandom);
      @(negedge clk);
      g++;
    end
    start = 1'b0;
    chk("churn_done_seen", 32'(done), 32'd1);
    chk("churn_out", 32'(out), 32'hF0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    // start held high across DONE is re-accepted on the IDLE edge
    @(negedge clk);
    din = 8'h81; shift_n = 4'd1; right_en = 1'b1; sign = 1'b1; start = 1'b1;
    @(negedge clk);
    g = 0;
    while (!done && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("held_out", 32'(out), 32'hC0);
    chk("held_ready_in_done", 32'(ready), 32'd0);
    @(negedge clk);
    chk("held_idle_ready", 32'(ready), 32'd1);
    @(negedge clk);
    chk("held_reaccept", 32'(ready), 32'd0);
    start = 1'b0;
    g = 0;
    while (!ready && g < 20) begin
      @(negedge clk);
      g++;
    end

    // Sweep: operands in steps of 5, every amount, every mode
    for (int unsigned d = 0; d < 256; d += 5) begin
      for (int unsigned s = 0; s < 16; s++) begin
        for (int unsigned m = 0; m < 3; m++) begin
          do_op(8'(d), 4'(s), (m != 0), (m == 2), res, edges);
          chk("sweep_out", 32'(res), 32'(golden(8'(d), 4'(s), (m != 0), (m == 2))));
          chk("sweep_lat", 32'(edges), 32'(clampn(4'(s))));
        end
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
